// File: rtl/slice_adder_seq.sv
// Sequential adder: WIDTH-bit operands summed one SLICE-bit slice per clock, LSB slice first.
// Define ADDER_SEQ_COUT_EN to expose the final carry on the cout port.
module slice_adder_seq #(
  parameter int WIDTH = 32,
  parameter int SLICE = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum
`ifdef ADDER_SEQ_COUT_EN
  ,
  output logic             cout
`endif
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IDXW-1:0] LAST = IDXW'(NSLICE - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_a, r_b, r_sum;
  logic             r_carry;
  logic [IDXW-1:0]  r_idx;

  logic [SLICE-1:0] w_as, w_bs;
  logic [SLICE:0]   w_add;

  // One shared SLICE-bit adder; the slice offset is picked by the running index.
  assign w_as  = r_a[int'(r_idx)*SLICE +: SLICE];
  assign w_bs  = r_b[int'(r_idx)*SLICE +: SLICE];
  assign w_add = {1'b0, w_as} + {1'b0, w_bs} + {{SLICE{1'b0}}, r_carry};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (in_valid)       w_state_nxt = RUN;
      RUN:     if (r_idx == LAST)  w_state_nxt = DONE;
      DONE:    if (out_ready)      w_state_nxt = IDLE;
      default:                     w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_idx   <= '0;
    end else begin
      case (r_state)
        IDLE: if (in_valid) begin
          r_a     <= a;
          r_b     <= b;
          r_carry <= cin;
          r_idx   <= '0;
        end
        RUN: begin
          r_sum[int'(r_idx)*SLICE +: SLICE] <= w_add[SLICE-1:0];
          r_carry <= w_add[SLICE];
          // Hold at the last slice so the index never wraps.
          if (r_idx != LAST) r_idx <= r_idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Handshake flags decode straight from the state register.
  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign sum       = r_sum;

`ifdef ADDER_SEQ_COUT_EN
  // Carry register is only reloaded on acceptance, so it is stable throughout DONE.
  assign cout = r_carry;
`endif

endmodule

// File: tb/tb_slice_adder_seq.sv
// Scoreboard bench for slice_adder_seq: driver pushes expected results, negedge monitor checks them.
module tb_slice_adder_seq;

  localparam int WIDTH  = 32;
  localparam int SLICE  = 8;
  localparam int NSLICE = WIDTH / SLICE;

  typedef struct {
    logic [WIDTH-1:0] sum;
    logic             cout;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             cin = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [WIDTH-1:0] sum;
`ifdef ADDER_SEQ_COUT_EN
  logic             cout;
`endif

  slice_adder_seq #(.WIDTH(WIDTH), .SLICE(SLICE)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum)
`ifdef ADDER_SEQ_COUT_EN
    , .cout(cout)
`endif
  );

  always #5 clk = ~clk;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  int   n_neg  = 0;
  int   acc_n  = 0;
  int   hs_n   = 0;
  bit   b2b_chk = 1'b0;
  bit   pov = 1'b0, prdy = 1'b0;
  logic [WIDTH-1:0] psum = '0;

  task automatic chk(input string nm, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      n_neg++;
      if (!rst_n) begin
        pov = 1'b0; prdy = 1'b0;
      end else begin
        if (in_valid && in_ready) begin
          if (b2b_chk) begin
            chk("accept_after_handshake", WIDTH'(n_neg - hs_n), WIDTH'(1));
            b2b_chk = 1'b0;
          end
          acc_n = n_neg;
        end
        if (out_valid && !pov)
          chk("latency", WIDTH'(n_neg - acc_n), WIDTH'(NSLICE + 1));
        if (out_valid && pov && !prdy) begin
          chk("sum_stable", sum, psum);
          chk("in_ready_in_done", WIDTH'(in_ready), WIDTH'(0));
        end
        if (out_valid && out_ready) begin
          hs_n = n_neg;
          if (q.size() == 0) begin
            chk("unexpected_result", WIDTH'(1), WIDTH'(0));
          end else begin
            e = q.pop_front();
            chk("sum", sum, e.sum);
`ifdef ADDER_SEQ_COUT_EN
            chk("cout", WIDTH'(cout), WIDTH'(e.cout));
`endif
          end
        end
        pov = out_valid; prdy = out_ready; psum = sum;
      end
    end
  end

  task automatic send(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_,
                      input logic tc, input logic [WIDTH-1:0] es, input logic ec);
    exp_t e;
    bit ok;
    e.sum = es; e.cout = ec;
    q.push_back(e);
    a = ta; b = tb_; cin = tc; in_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1'b1; break; end
    end
    if (!ok) chk("accept_timeout", WIDTH'(1), WIDTH'(0));
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = 32'hA5A5_5A5A; b = 32'h0F0F_F0F0; cin = 1'b1;
  endtask

  task automatic drain();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (q.size() == 0) begin ok = 1'b1; break; end
    end
    if (!ok) chk("drain_timeout", WIDTH'(1), WIDTH'(0));
    @(posedge clk); #1;
  endtask

  initial begin
    bit ok;
    #1;
    chk("reset_in_ready", WIDTH'(in_ready), WIDTH'(1));
    chk("reset_out_valid", WIDTH'(out_valid), WIDTH'(0));
    chk("reset_sum", sum, '0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    send(32'h1234_5678, 32'h1111_1111, 1'b0, 32'h2345_6789, 1'b0); drain();
    send(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1); drain();
    send(32'h0000_00FF, 32'h0000_0000, 1'b1, 32'h0000_0100, 1'b0); drain();
    send(32'h89AB_CDEF, 32'h7654_3210, 1'b1, 32'h0000_0000, 1'b1); drain();

    // Back-pressure with a second operand waiting upstream.
    out_ready = 1'b0;
    send(32'h0000_FFFF, 32'h0000_0001, 1'b0, 32'h0001_0000, 1'b0);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (out_valid) begin ok = 1'b1; break; end
    end
    if (!ok) chk("out_valid_timeout", WIDTH'(1), WIDTH'(0));
    @(posedge clk); #1;
    begin
      exp_t e;
      e.sum = 32'h1122_3344; e.cout = 1'b0;
      q.push_back(e);
    end
    a = 32'h0102_0304; b = 32'h1020_3040; cin = 1'b0; in_valid = 1'b1;
    repeat (10) @(posedge clk);
    #1 out_ready = 1'b1; b2b_chk = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1'b1; break; end
    end
    if (!ok) chk("b2b_accept_timeout", WIDTH'(1), WIDTH'(0));
    @(posedge clk); #1;
    in_valid = 1'b0; a = '1; b = '1;
    drain();

    // Abort mid-run with reset, then a fresh transaction.
    send(32'hDEAD_BEEF, 32'h0000_0001, 1'b0, 32'hDEAD_BEF0, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    q.delete();
    #1;
    chk("abort_in_ready", WIDTH'(in_ready), WIDTH'(1));
    chk("abort_out_valid", WIDTH'(out_valid), WIDTH'(0));
    chk("abort_sum", sum, '0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    send(32'h0000_0003, 32'h0000_0004, 1'b0, 32'h0000_0007, 1'b0); drain();

    send(32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1); drain();

    chk("queue_empty", WIDTH'(q.size()), WIDTH'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
